// File: rtl/uart_rx_core.sv
// uart_rx_core: 8N1 UART receiver with a single-entry valid/ready holding register.
// RXD is synchronized through SYNC_STAGES flops, then a baud counter drives an
// IDLE/START/DATA/STOP FSM that samples each bit at its centre.
// Optional build macro UART_RX_PARITY_EN switches the frame to 8E1, adds a PARITY
// state and a parity_err pulse output.
module uart_rx_core #(
  parameter int CLKS_PER_BIT = 16,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RXD,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err,
`endif
  output logic       busy
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'((CLKS_PER_BIT / 2) - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;
`endif

  state_t               state_reg, state_next;
  logic [SYNC_STAGES-1:0] sync_reg;
  logic                 rxs;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic [2:0]           idx_reg, idx_next;
  logic [7:0]           shift_reg, shift_next;
  logic [7:0]           rx_data_reg, rx_data_next;
  logic                 rx_valid_reg, rx_valid_next;
  logic                 frame_err_reg, frame_err_next;
  logic                 overrun_reg, overrun_next;
  logic                 accept;
`ifdef UART_RX_PARITY_EN
  logic                 parity_bit_reg, parity_bit_next;
  logic                 parity_err_reg, parity_err_next;
`endif

  // Metastability synchronizer: shift RXD in, idle value is high.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_reg <= '1;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], RXD};
    end
  end

  assign rxs    = sync_reg[SYNC_STAGES-1];
  assign accept = rx_valid_reg & rx_ready;

  // State, counters, holding register and pulse flags.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg      <= S_IDLE;
      cnt_reg        <= '0;
      idx_reg        <= '0;
      shift_reg      <= '0;
      rx_data_reg    <= '0;
      rx_valid_reg   <= 1'b0;
      frame_err_reg  <= 1'b0;
      overrun_reg    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bit_reg <= 1'b0;
      parity_err_reg <= 1'b0;
`endif
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      idx_reg        <= idx_next;
      shift_reg      <= shift_next;
      rx_data_reg    <= rx_data_next;
      rx_valid_reg   <= rx_valid_next;
      frame_err_reg  <= frame_err_next;
      overrun_reg    <= overrun_next;
`ifdef UART_RX_PARITY_EN
      parity_bit_reg <= parity_bit_next;
      parity_err_reg <= parity_err_next;
`endif
    end
  end

  // Next-state logic: bit timing, sampling and the stop-bit delivery decision.
  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg + 1'b1;
    idx_next        = idx_reg;
    shift_next      = shift_reg;
    rx_data_next    = rx_data_reg;
    rx_valid_next   = rx_valid_reg & ~accept;
    frame_err_next  = 1'b0;
    overrun_next    = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_bit_next = parity_bit_reg;
    parity_err_next = 1'b0;
`endif

    case (state_reg)
      S_IDLE: begin
        cnt_next = '0;
        if (!rxs) begin
          state_next = S_START;
        end
      end

      S_START: begin
        // Confirm the start bit at its centre; a high line here is a glitch.
        if (cnt_reg == CNT_MID) begin
          cnt_next = '0;
          if (!rxs) begin
            state_next = S_DATA;
            idx_next   = 3'd0;
          end else begin
            state_next = S_IDLE;
          end
        end
      end

      S_DATA: begin
        // Counter wraps one bit period after the previous centre.
        if (cnt_reg == CNT_LAST) begin
          cnt_next            = '0;
          shift_next[idx_reg] = rxs;
          if (idx_reg == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_next = S_PARITY;
`else
            state_next = S_STOP;
`endif
          end else begin
            idx_next = idx_reg + 3'd1;
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (cnt_reg == CNT_LAST) begin
          cnt_next        = '0;
          parity_bit_next = rxs;
          state_next      = S_STOP;
        end
      end
`endif

      S_STOP: begin
        // Decide at the stop-bit centre and go idle early so a back-to-back
        // start edge is not missed.
        if (cnt_reg == CNT_LAST) begin
          cnt_next   = '0;
          state_next = S_IDLE;
          if (!rxs) begin
            frame_err_next = 1'b1;
`ifdef UART_RX_PARITY_EN
          end else if ((^shift_reg ^ parity_bit_reg) != 1'b0) begin
            parity_err_next = 1'b1;
`endif
          end else if (!rx_valid_reg || accept) begin
            rx_data_next  = shift_reg;
            rx_valid_next = 1'b1;
          end else begin
            overrun_next = 1'b1;
          end
        end
      end

      default: begin
        state_next = S_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  assign rx_data    = rx_data_reg;
  assign rx_valid   = rx_valid_reg;
  assign frame_err  = frame_err_reg;
  assign overrun    = overrun_reg;
  assign busy       = (state_reg != S_IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_reg;
`endif

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed testbench for uart_rx_core: reset/idle, single byte latency and
// handshake, back-to-back frames, overrun, framing error and glitch rejection,
// reset in the middle of a frame (plus bad parity when UART_RX_PARITY_EN is set).
module tb_uart_rx_core;

  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam int LAT_MAX = (19 * CPB) / 2 + 3 + CPB;
`else
  localparam int LAT_MAX = (19 * CPB) / 2 + 3;
`endif

  logic       CLK;
  logic       RST;
  logic       RXD;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  logic       busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
  logic       par_flip;
  int         pe_cnt = 0;
`endif

  int total = 0;
  int bad   = 0;

  int fe_cnt   = 0;
  int ov_cnt   = 0;
  int both_cnt = 0;
  logic [7:0] beats[$];

  uart_rx_core #(
    .CLKS_PER_BIT(CPB),
    .SYNC_STAGES (2)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .RXD       (RXD),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .busy      (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Event monitor, sampled on the falling edge.
  always @(negedge CLK) begin
    if (frame_err) fe_cnt++;
    if (overrun) ov_cnt++;
    if (frame_err && overrun) both_cnt++;
`ifdef UART_RX_PARITY_EN
    if (parity_err) pe_cnt++;
`endif
    if (rx_valid && rx_ready) beats.push_back(rx_data);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive one frame starting at the current falling edge; line left high.
  task automatic send_frame(input logic [7:0] d, input logic stop_b);
    RXD = 1'b0;
    repeat (CPB) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      RXD = d[i];
      repeat (CPB) @(negedge CLK);
    end
`ifdef UART_RX_PARITY_EN
    RXD = (^d) ^ par_flip;
    repeat (CPB) @(negedge CLK);
`endif
    RXD = stop_b;
    repeat (CPB) @(negedge CLK);
    RXD = 1'b1;
  endtask

  task automatic drain_one();
    rx_ready = 1'b1;
    @(negedge CLK);
    rx_ready = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_reset();
    logic [11:0] obs;
    RXD = 1'b1;
    rx_ready = 1'b0;
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge CLK);
      obs = {rx_data, rx_valid, frame_err, overrun, busy};
      total++;
      if (obs !== 12'h000) begin
        bad++;
        $display("FAIL reset_idle cycle %0d: got %h expected 000", c, obs);
      end
    end
    $display("test_reset: done");
  endtask

  task automatic test_single();
    int lat;
    lat = 0;
    rx_ready = 1'b0;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        for (int c = 1; c <= LAT_MAX + 20; c++) begin
          @(negedge CLK);
          if (rx_valid && lat == 0) lat = c;
        end
      end
    join
    total++;
    if (lat == 0 || lat > LAT_MAX) begin
      bad++;
      $display("FAIL single_latency: got %0d cycles expected 1..%0d", lat, LAT_MAX);
    end
    total++;
    if (rx_valid !== 1'b1 || rx_data !== 8'hA5) begin
      bad++;
      $display("FAIL single_data: got valid=%b data=%h expected valid=1 data=a5", rx_valid, rx_data);
    end
    rx_ready = 1'b1;
    @(negedge CLK);
    rx_ready = 1'b0;
    total++;
    if (rx_valid !== 1'b0) begin
      bad++;
      $display("FAIL single_accept: got valid=%b expected 0", rx_valid);
    end
    $display("test_single: byte a5 latency %0d", lat);
  endtask

  task automatic test_back_to_back();
    int b0, fe0, ov0;
    logic [7:0] exp_b[3];
    exp_b[0] = 8'h00;
    exp_b[1] = 8'hFF;
    exp_b[2] = 8'h3C;
    b0 = beats.size();
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    rx_ready = 1'b1;
    for (int i = 0; i < 3; i++) send_frame(exp_b[i], 1'b1);
    repeat (20) @(negedge CLK);
    rx_ready = 1'b0;
    total++;
    if (beats.size() - b0 !== 3) begin
      bad++;
      $display("FAIL b2b_count: got %0d beats expected 3", beats.size() - b0);
    end else begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (beats[b0 + i] !== exp_b[i]) begin
          bad++;
          $display("FAIL b2b_beat%0d: got %h expected %h", i, beats[b0 + i], exp_b[i]);
        end
      end
    end
    total++;
    if (fe_cnt - fe0 !== 0 || ov_cnt - ov0 !== 0) begin
      bad++;
      $display("FAIL b2b_flags: got fe=%0d ov=%0d expected 0 0", fe_cnt - fe0, ov_cnt - ov0);
    end
    $display("test_back_to_back: 3 frames sent");
  endtask

  task automatic test_overrun();
    int fe0, ov0;
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    repeat (10) @(negedge CLK);
    total++;
    if (ov_cnt - ov0 !== 1) begin
      bad++;
      $display("FAIL overrun_pulse: got %0d pulse cycles expected 1", ov_cnt - ov0);
    end
    total++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h11) begin
      bad++;
      $display("FAIL overrun_hold: got valid=%b data=%h expected valid=1 data=11", rx_valid, rx_data);
    end
    total++;
    if (fe_cnt - fe0 !== 0) begin
      bad++;
      $display("FAIL overrun_fe: got %0d expected 0", fe_cnt - fe0);
    end
    drain_one();
    $display("test_overrun: 11 then 22");
  endtask

  task automatic test_framing_glitch();
    int fe0, ov0, b0;
    logic seen_busy;
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    b0 = beats.size();
    rx_ready = 1'b0;
    send_frame(8'h55, 1'b0);
    repeat (40) @(negedge CLK);
    total++;
    if (fe_cnt - fe0 !== 1) begin
      bad++;
      $display("FAIL frame_err_pulse: got %0d expected 1", fe_cnt - fe0);
    end
    total++;
    if (rx_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL frame_err_state: got valid=%b busy=%b expected 0 0", rx_valid, busy);
    end
    seen_busy = 1'b0;
    RXD = 1'b0;
    repeat (4) @(negedge CLK);
    RXD = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge CLK);
      if (busy) seen_busy = 1'b1;
    end
    total++;
    if (seen_busy !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL glitch_return: got seen_busy=%b busy=%b expected 1 0", seen_busy, busy);
    end
    total++;
    if (fe_cnt - fe0 !== 1 || ov_cnt - ov0 !== 0 || rx_valid !== 1'b0 || beats.size() != b0) begin
      bad++;
      $display("FAIL glitch_flags: got fe=%0d ov=%0d valid=%b expected 1 0 0", fe_cnt - fe0, ov_cnt - ov0, rx_valid);
    end
    $display("test_framing_glitch: done");
  endtask

  task automatic test_reset_midframe();
    int fe0, ov0, b0;
    logic [7:0] d;
    d = 8'h81;
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    rx_ready = 1'b0;
    RXD = 1'b0;
    repeat (CPB) @(negedge CLK);
    for (int i = 0; i < 4; i++) begin
      RXD = d[i];
      repeat (CPB) @(negedge CLK);
    end
    RXD = d[4];
    repeat (CPB / 2) @(negedge CLK);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL midframe_busy: got %b expected 1", busy);
    end
    RST = 1'b1;
    RXD = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    total++;
    if (busy !== 1'b0 || rx_valid !== 1'b0) begin
      bad++;
      $display("FAIL midframe_reset: got busy=%b valid=%b expected 0 0", busy, rx_valid);
    end
    repeat (30) @(negedge CLK);
    send_frame(8'h7E, 1'b1);
    repeat (10) @(negedge CLK);
    total++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h7E) begin
      bad++;
      $display("FAIL midframe_deliver: got valid=%b data=%h expected valid=1 data=7e", rx_valid, rx_data);
    end
    total++;
    if (fe_cnt - fe0 !== 0 || ov_cnt - ov0 !== 0) begin
      bad++;
      $display("FAIL midframe_flags: got fe=%0d ov=%0d expected 0 0", fe_cnt - fe0, ov_cnt - ov0);
    end
    b0 = beats.size();
    drain_one();
    total++;
    if (beats.size() - b0 !== 1 || rx_valid !== 1'b0) begin
      bad++;
      $display("FAIL midframe_drain: got beats=%0d valid=%b expected 1 0", beats.size() - b0, rx_valid);
    end
    $display("test_reset_midframe: only 7e delivered");
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    int pe0, fe0;
    pe0 = pe_cnt;
    fe0 = fe_cnt;
    rx_ready = 1'b0;
    par_flip = 1'b1;
    send_frame(8'h7E, 1'b1);
    par_flip = 1'b0;
    repeat (10) @(negedge CLK);
    total++;
    if (pe_cnt - pe0 !== 1 || fe_cnt - fe0 !== 0 || rx_valid !== 1'b0) begin
      bad++;
      $display("FAIL parity_err: got pe=%0d fe=%0d valid=%b expected 1 0 0", pe_cnt - pe0, fe_cnt - fe0, rx_valid);
    end
    $display("test_parity: bad parity on 7e");
  endtask
`endif

  task automatic test_exclusive();
    total++;
    if (both_cnt !== 0) begin
      bad++;
      $display("FAIL flags_exclusive: got %0d overlapping cycles expected 0", both_cnt);
    end
    $display("test_exclusive: done");
  endtask

  initial begin
    RST = 1'b1;
    RXD = 1'b1;
    rx_ready = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_flip = 1'b0;
`endif
    @(negedge CLK);
    test_reset();
    test_single();
    test_back_to_back();
    test_overrun();
    test_framing_glitch();
    test_reset_midframe();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_exclusive();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
